data_mem_wb: RTL and testbench
==============================

# data_mem_wb

Posted-write data memory: the responder on the core's data-memory bus (`data_ce_o`/`data_we_o`/`data_addr_o`/`data_o` in, `data_i` out). Stores are absorbed into a small in-order write buffer and committed to a single-port word array in later cycles. Loads are answered combinationally, with store-to-load forwarding from the buffer. It drops into the SoC bench in place of the plain data memory and exposes a committed `verify` word for end-of-run checking.

## Interface
- `DEPTH`, default 1024: number of 32-bit words in the array; power of two.
- `WB_DEPTH`, default 4: write-buffer entries; power of two, at least 2.
- `VERIFY_IDX`, default 0: word index mirrored on `verify`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `ce` input, 1 bit: access request this cycle.
- `we` input, 1 bit: 1 = store, 0 = load; valid only when `ce`=1.
- `addr` input, 32 bits: byte address. Word index is `addr[log2(DEPTH)+1:2]`; `addr[1:0]` and the upper bits are ignored.
- `data_i` input, 32 bits: store data.
- `data_o` output, 32 bits: load data, combinational.
- `verify` output, 32 bits: committed array word at `VERIFY_IDX`.
- `wb_empty` output, 1 bit: write buffer holds no entries.

## Operation
- State:
  - `array[DEPTH]`: single port, so one array operation per cycle (one read or one commit).
  - Circular write buffer `{valid, idx, data}` × `WB_DEPTH`, with head pointer, tail pointer and `count` (0..`WB_DEPTH`).
- Cycle classes:
  - Load: `ce`=1, `we`=0.
  - Store: `ce`=1, `we`=1.
  - Idle: `ce`=0.
- Load:
  - `data_o` is the data of the youngest valid buffer entry whose idx matches.
  - If no entry matches, `data_o` = `array[idx]`.
  - Nothing drains from the buffer.
- Store:
  - Entry `{idx, data_i}` is enqueued at the tail.
  - If `count`=`WB_DEPTH`, the head entry is committed to the array in the same cycle. The buffer never overflows and there is no stall output.
  - If `count`<`WB_DEPTH`, nothing commits.
- Idle: if `count`>0, the head entry is committed to the array and dequeued.
- `data_o` = 0 whenever the cycle is not a load.
- Same-index entries are kept separately and committed strictly in FIFO order. Final array value = last store.
- Full buffer with a store to the same idx as the head: the head commits first and the new entry is enqueued. Result is correct ordering.
- `count` next value:
  - +1 on a store with `count`<`WB_DEPTH`.
  - Unchanged on a store when full.
  - −1 on an idle cycle with `count`>0.
  - Unchanged otherwise.
- `verify` = `array[VERIFY_IDX]` and reflects committed data only.
- `wb_empty` = (`count`==0).

## Timing
- Reset (`rst`=0, asynchronous):
  - Pointers and `count` = 0; all valid bits = 0.
  - All array words = 0.
  - Outputs: `data_o`=0, `verify`=0, `wb_empty`=1.
- Reset asserted mid-run discards every buffered store; uncommitted data is lost by definition.
- Load latency 0: `data_o` is valid in the same cycle `ce`/`addr` are presented, matching the core's MEM stage.
- Store: visible to loads from the cycle after the `clk` edge that accepts it, through forwarding.
- Commit: array, `verify` and pointers update on the `clk` edge that ends the commit cycle.
- A store followed immediately by a load to the same address returns the new data.
- Drain rate: one entry per idle cycle. A full buffer needs `WB_DEPTH` idle cycles to become empty.
- Pointers wrap modulo `WB_DEPTH`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release → `data_o`=0, `verify`=0, `wb_empty`=1. A load from 0x10 returns 0.
- Forwarding:
  - Store 0x11111111 to 0x40, then load 0x40 the next cycle → 0x11111111 while `wb_empty`=0.
  - After 1 idle cycle, `wb_empty`=1 and a load of 0x40 still returns 0x11111111 from the array.
- Youngest wins:
  - Stores 0xA to 0x8, then 0xB to 0x8, then a load of 0x8 → 0xB.
  - After 2 idle cycles, the array word at index 2 = 0xB.
- Full-buffer commit (`WB_DEPTH`=4):
  - 6 back-to-back stores of values 1..6 to word indexes 0..5 → `count` saturates at 4, and indexes 0 and 1 commit during stores 5 and 6.
  - With `VERIFY_IDX`=0, `verify`=1 after the 5th store edge.
- Loads block draining: 2 stores followed by 5 loads keep `wb_empty`=0 throughout. One idle cycle then commits exactly one entry.
- Reset mid-run: 3 stores pending to `VERIFY_IDX`, then `rst` pulsed low → `wb_empty`=1 immediately, and `verify`=0 after release.

Source files
------------

// File: rtl/data_mem_wb.sv
// rtl/data_mem_wb.sv - posted-write data memory with in-order write buffer and store-to-load forwarding
// Loads answer combinationally; stores queue and commit to the single-port array on idle cycles.
module data_mem_wb #(
  parameter int DEPTH      = 1024,
  parameter int WB_DEPTH   = 4,
  parameter int VERIFY_IDX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] verify,
  output logic        wb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(WB_DEPTH);
  localparam logic [AW-1:0] VIDX = AW'(VERIFY_IDX);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(WB_DEPTH);

  logic [31:0]   r_array    [DEPTH];
  logic          r_wb_valid [WB_DEPTH];
  logic [AW-1:0] r_wb_idx   [WB_DEPTH];
  logic [31:0]   r_wb_data  [WB_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic [AW-1:0] w_idx;
  logic          w_load;
  logic          w_store;
  logic          w_full;
  logic          w_commit;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;
  logic          w_unused;

  assign w_idx    = addr[AW+1:2];
  assign w_unused = &{1'b0, addr[31:AW+2], addr[1:0]};
  assign w_load   = ce && !we;
  assign w_store  = ce && we;
  assign w_full   = (r_count == FULL_COUNT);
  // A full buffer makes room for a store by committing its head in the same cycle.
  assign w_commit = (w_store && w_full) || (!ce && (r_count != '0));

  // Walk oldest to youngest so the last match, the youngest store, wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (((PW+1)'(k) < r_count) && r_wb_valid[r_head + PW'(k)] &&
          (r_wb_idx[r_head + PW'(k)] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[r_head + PW'(k)];
      end
    end
  end

  assign data_o   = w_load ? (w_fwd_hit ? w_fwd_data : r_array[w_idx]) : '0;
  assign verify   = r_array[VIDX];
  assign wb_empty = (r_count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_wb_valid[i] <= 1'b0;
        r_wb_idx[i]   <= '0;
        r_wb_data[i]  <= '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        r_array[j] <= '0;
      end
    end else begin
      if (w_commit) begin
        r_array[r_wb_idx[r_head]] <= r_wb_data[r_head];
      end
      if (w_store) begin
        // When full, tail equals head: the old head is read for commit above before being overwritten.
        r_wb_valid[r_tail] <= 1'b1;
        r_wb_idx[r_tail]   <= w_idx;
        r_wb_data[r_tail]  <= data_i;
        r_tail             <= r_tail + PW'(1);
        if (w_full) begin
          r_head <= r_head + PW'(1);
        end else begin
          r_count <= r_count + (PW+1)'(1);
        end
      end else if (w_commit) begin
        r_wb_valid[r_head] <= 1'b0;
        r_head             <= r_head + PW'(1);
        r_count            <= r_count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_wb.sv
// tb/tb_data_mem_wb.sv - self-checking bench for data_mem_wb against a queue-based memory model
module tb_data_mem_wb;
  localparam int DEPTH = 1024;
  localparam int WBD   = 4;
  localparam int VIDX  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [31:0] verify;
  logic        wb_empty;

  int vectors = 0;
  int miscompares = 0;

  data_mem_wb #(.DEPTH(DEPTH), .WB_DEPTH(WBD), .VERIFY_IDX(VIDX)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .data_i(data_i),
    .data_o(data_o), .verify(verify), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_mem [int];
  ent_t        m_q [$];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] m_get(input int idx);
    return m_mem.exists(idx) ? m_mem[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input int idx);
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].idx == idx) return m_q[i].data;
    return m_get(idx);
  endfunction

  function automatic logic [31:0] m_data_o();
    return (ce && !we) ? m_load(idx_of(addr)) : 32'h0;
  endfunction

  task automatic m_commit();
    ent_t e;
    e = m_q.pop_front();
    m_mem[e.idx] = e.data;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_mem.delete();
  endtask

  task automatic apply(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    ce = c; we = w; addr = a; data_i = d;
    @(negedge clk);
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (ce && we) begin
      e.idx = idx_of(addr);
      e.data = data_i;
      m_q.push_back(e);
      if (m_q.size() > WBD) m_commit();
    end else if (!ce && m_q.size() > 0) begin
      m_commit();
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (data_o !== 32'h0 || verify !== 32'h0 || wb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: got data_o=%h verify=%h wb_empty=%b, want 0/0/1", data_o, verify, wb_empty);
    end
    rst = 1'b1;
    m_reset();
    tick();
    apply(1'b1, 1'b0, 32'h10, 32'h0);
    vectors++;
    if (data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_load: got %h want 00000000", data_o);
    end
    tick();
  endtask

  task automatic test_forwarding();
    apply(1'b1, 1'b1, 32'h40, 32'h11111111);
    tick();
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    vectors++;
    if (data_o !== 32'h11111111 || wb_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_load: got data_o=%h wb_empty=%b, want 11111111/0", data_o, wb_empty);
    end
    tick();
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    vectors++;
    if (data_o !== 32'h11111111 || wb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fwd_array: got data_o=%h wb_empty=%b, want 11111111/1", data_o, wb_empty);
    end
    tick();
  endtask

  task automatic test_youngest();
    apply(1'b1, 1'b1, 32'h8, 32'hA);
    tick();
    apply(1'b1, 1'b1, 32'h8, 32'hB);
    tick();
    apply(1'b1, 1'b0, 32'h8, 32'h0);
    vectors++;
    if (data_o !== 32'hB) begin
      miscompares++;
      $display("FAIL youngest_fwd: got %h want 0000000b", data_o);
    end
    tick();
    repeat (2) begin
      apply(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    apply(1'b1, 1'b0, 32'h8, 32'h0);
    vectors++;
    if (data_o !== 32'hB || wb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL youngest_commit: got data_o=%h wb_empty=%b, want 0000000b/1", data_o, wb_empty);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b1, 32'(i * 4), 32'(i + 1));
      tick();
      if (i == 3) begin
        vectors++;
        if (verify !== 32'h0) begin
          miscompares++;
          $display("FAIL full_no_early_commit: verify got %h want 00000000", verify);
        end
      end
      if (i == 4) begin
        vectors++;
        if (verify !== 32'h1) begin
          miscompares++;
          $display("FAIL full_head_commit: verify got %h want 00000001", verify);
        end
      end
    end
    apply(1'b1, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (data_o !== 32'h1) begin
      miscompares++;
      $display("FAIL full_load_idx0: got %h want 00000001", data_o);
    end
    tick();
    for (int i = 0; i < WBD; i++) begin
      apply(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      vectors++;
      if (wb_empty !== (i == WBD - 1)) begin
        miscompares++;
        $display("FAIL full_drain_%0d: wb_empty got %b want %b", i, wb_empty, (i == WBD - 1));
      end
    end
    apply(1'b1, 1'b0, 32'h4, 32'h0);
    vectors++;
    if (data_o !== 32'h2) begin
      miscompares++;
      $display("FAIL full_load_idx1: got %h want 00000002", data_o);
    end
    tick();
  endtask

  task automatic test_loads_block();
    apply(1'b1, 1'b1, 32'h100, 32'hCAFE0001);
    tick();
    apply(1'b1, 1'b1, 32'h104, 32'hCAFE0002);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 32'h104, 32'h0);
      vectors++;
      if (wb_empty !== 1'b0 || data_o !== 32'hCAFE0002) begin
        miscompares++;
        $display("FAIL loads_block_%0d: got wb_empty=%b data_o=%h want 0/cafe0002", i, wb_empty, data_o);
      end
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    vectors++;
    if (wb_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL loads_one_commit: wb_empty got %b want 0", wb_empty);
    end
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    vectors++;
    if (wb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL loads_second_commit: wb_empty got %b want 1", wb_empty);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 32'(VIDX * 4), 32'hDEAD0000 + 32'(i));
      tick();
    end
    ce = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (wb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_empty: wb_empty got %b want 1", wb_empty);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    vectors++;
    if (verify !== 32'h0) begin
      miscompares++;
      $display("FAIL midrun_verify: got %h want 00000000", verify);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] a;
    logic        c;
    logic        w;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) == 1);
      a = {r[31:12], 10'(32'($urandom_range(0, 7))), r[1:0]};
      apply(c, w, a, $urandom);
      vectors++;
      if (data_o !== m_data_o() || wb_empty !== (m_q.size() == 0) || verify !== m_get(VIDX)) begin
        miscompares++;
        $display("FAIL random_%0d: got data_o=%h wb_empty=%b verify=%h want %h/%b/%h",
                 n, data_o, wb_empty, verify, m_data_o(), (m_q.size() == 0), m_get(VIDX));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_youngest();
    test_back_to_back();
    test_loads_block();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
